// File: rtl/reg_file_ctrl.sv
// Register file with one write port, one registered read port, byte-lane
// write enables and a resettable control word at address 0 whose bit 1 is a
// self-clearing START strobe.
module reg_file_ctrl #(
   parameter int unsigned           DATA_WIDTH = 24,
   parameter int unsigned           ADDR_WIDTH = 12,
   parameter int unsigned           DEPTH      = 4096,
   parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    rd_err,
   output logic                    wr_err,
   output logic [DATA_WIDTH-1:0]   ctrl_reg,
   output logic                    start_pulse
);

   localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_L      = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] START_MASK   = DATA_WIDTH'(2);
   localparam logic [DATA_WIDTH-1:0] CTRL_RESET_L = CTRL_RESET & ~START_MASK;

   // Word 0 lives in ctrl_q; mem_q[0] is never written or read.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_err_q, rd_err_d;
   logic                  wr_err_q, wr_err_d;
   logic                  start_pulse_q, start_pulse_d;

   logic                  wr_in_range_c, rd_in_range_c;
   logic                  wr_is_ctrl_c, rd_is_ctrl_c;
   logic                  wr_hit_c, same_addr_c;
   logic [IDX_W-1:0]      wr_idx_c, rd_idx_c;
   logic [NUM_LANES-1:0]  mem_lane_we_c;
   logic [DATA_WIDTH-1:0] rd_word_c;

   // Address decode and range checks for both ports
   always_comb begin
      wr_in_range_c = {1'b0, wr_addr} < DEPTH_L;
      rd_in_range_c = {1'b0, rd_addr} < DEPTH_L;
      wr_is_ctrl_c  = (wr_addr == '0);
      rd_is_ctrl_c  = (rd_addr == '0);
      wr_hit_c      = wr_en && wr_in_range_c;
      same_addr_c   = wr_hit_c && (wr_addr == rd_addr);
      wr_idx_c      = wr_in_range_c ? IDX_W'(wr_addr) : '0;
      rd_idx_c      = rd_in_range_c ? IDX_W'(rd_addr) : '0;
      mem_lane_we_c = (wr_hit_c && !wr_is_ctrl_c) ? wr_be : '0;
   end

   // Post-write view of the read word (write-first on address collision)
   always_comb begin
      rd_word_c = rd_is_ctrl_c ? ctrl_q : mem_q[rd_idx_c];
      if (same_addr_c) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_be[i]) rd_word_c[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
      if (rd_is_ctrl_c) rd_word_c = rd_word_c & ~START_MASK;
   end

   // Next-state for control word, read outputs and error/start strobes
   always_comb begin
      ctrl_d        = ctrl_q;
      rd_data_d     = rd_data_q;
      rd_valid_d    = 1'b0;
      rd_err_d      = 1'b0;
      wr_err_d      = wr_en && !wr_in_range_c;
      start_pulse_d = 1'b0;

      if (wr_hit_c && wr_is_ctrl_c) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_be[i]) ctrl_d[8*i +: 8] = wr_data[8*i +: 8];
         end
         ctrl_d        = ctrl_d & ~START_MASK;
         start_pulse_d = wr_be[0] && wr_data[1];
      end

      if (rd_en) begin
         rd_valid_d = 1'b1;
         rd_err_d   = !rd_in_range_c;
         rd_data_d  = rd_in_range_c ? rd_word_c : '0;
      end
   end

   // Resettable state: control word and all output flops
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q        <= CTRL_RESET_L;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         rd_err_q      <= 1'b0;
         wr_err_q      <= 1'b0;
         start_pulse_q <= 1'b0;
      end else begin
         ctrl_q        <= ctrl_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         rd_err_q      <= rd_err_d;
         wr_err_q      <= wr_err_d;
         start_pulse_q <= start_pulse_d;
      end
   end

   // Storage array (words 1..DEPTH-1), not reset, per-lane writes
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (mem_lane_we_c[i]) mem_q[wr_idx_c][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign rd_err      = rd_err_q;
   assign wr_err      = wr_err_q;
   assign ctrl_reg    = ctrl_q;
   assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: reset, directed vector table, reset during a read,
// then randomized traffic against a word-level reference model.
module tb_reg_file_ctrl;

   localparam int unsigned DW    = 24;
   localparam int unsigned AW    = 12;
   localparam int unsigned DEPTH = 3000;
   localparam int unsigned NB    = DW / 8;
   localparam int unsigned NMOD  = 16;

   logic            clock;
   logic            reset_n;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [NB-1:0]   wr_be;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic [DW-1:0]   rd_data;
   logic            rd_valid;
   logic            rd_err;
   logic            wr_err;
   logic [DW-1:0]   ctrl_reg;
   logic            start_pulse;

   reg_file_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .CTRL_RESET (24'h000F03)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_err      (rd_err),
      .wr_err      (wr_err),
      .ctrl_reg    (ctrl_reg),
      .start_pulse (start_pulse)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [NB-1:0] be;
      logic          re;
      logic [AW-1:0] ra;
      logic          e_valid;
      logic          e_err;
      logic [DW-1:0] e_data;
      logic          e_werr;
      logic          e_start;
      logic [DW-1:0] e_ctrl;
   } vec_t;

   vec_t          vecs [16];
   int            pass_cnt = 0;
   int            total_cnt = 0;
   logic [DW-1:0] model [NMOD];
   logic [DW-1:0] exp_rd;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One cycle of traffic checked against the word-level model
   task automatic model_cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra);
      logic [DW-1:0] w;
      logic          e_werr, e_start, e_valid, e_err;
      e_werr  = we && (int'(wa) >= int'(DEPTH));
      e_start = we && (wa == 0) && be[0] && wd[1];
      if (we && int'(wa) < int'(NMOD)) begin
         w = model[wa];
         for (int i = 0; i < int'(NB); i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
         if (wa == 0) w[1] = 1'b0;
         model[wa] = w;
      end
      e_valid = re;
      e_err   = re && (int'(ra) >= int'(DEPTH));
      if (re) exp_rd = e_err ? '0 : model[ra];
      drive(we, wa, wd, be, re, ra);
      step();
      chk("rnd_rd_valid", DW'(rd_valid), DW'(e_valid));
      chk("rnd_rd_err", DW'(rd_err), DW'(e_err));
      chk("rnd_rd_data", rd_data, exp_rd);
      chk("rnd_wr_err", DW'(wr_err), DW'(e_werr));
      chk("rnd_start", DW'(start_pulse), DW'(e_start));
      chk("rnd_ctrl", ctrl_reg, model[0]);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEPTH, 4095));
      return AW'($urandom_range(0, NMOD - 1));
   endfunction

   initial begin
      //           we  wa        wd            be      re  ra        v     e     data          werr  st    ctrl
      vecs[0]  = '{1'b1, 12'd5,    24'hAABBCC, 3'b111, 1'b0, 12'd0,    1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000F01};
      vecs[1]  = '{1'b1, 12'd5,    24'h112233, 3'b010, 1'b0, 12'd0,    1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'h000F01};
      vecs[2]  = '{1'b0, 12'd0,    24'h000000, 3'b000, 1'b1, 12'd5,    1'b1, 1'b0, 24'hAA22CC, 1'b0, 1'b0, 24'h000F01};
      vecs[3]  = '{1'b0, 12'd0,    24'h000000, 3'b000, 1'b0, 12'd0,    1'b0, 1'b0, 24'hAA22CC, 1'b0, 1'b0, 24'h000F01};
      vecs[4]  = '{1'b1, 12'd7,    24'h000001, 3'b111, 1'b0, 12'd0,    1'b0, 1'b0, 24'hAA22CC, 1'b0, 1'b0, 24'h000F01};
      vecs[5]  = '{1'b1, 12'd7,    24'hFFFFFF, 3'b001, 1'b1, 12'd7,    1'b1, 1'b0, 24'h0000FF, 1'b0, 1'b0, 24'h000F01};
      vecs[6]  = '{1'b1, 12'd3000, 24'h123456, 3'b111, 1'b1, 12'd7,    1'b1, 1'b0, 24'h0000FF, 1'b1, 1'b0, 24'h000F01};
      vecs[7]  = '{1'b0, 12'd0,    24'h000000, 3'b000, 1'b1, 12'd3000, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0, 24'h000F01};
      vecs[8]  = '{1'b1, 12'd0,    24'h000007, 3'b111, 1'b0, 12'd0,    1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'h000005};
      vecs[9]  = '{1'b0, 12'd0,    24'h000000, 3'b000, 1'b1, 12'd0,    1'b1, 1'b0, 24'h000005, 1'b0, 1'b0, 24'h000005};
      vecs[10] = '{1'b1, 12'd0,    24'hAB0002, 3'b101, 1'b1, 12'd0,    1'b1, 1'b0, 24'hAB0000, 1'b0, 1'b1, 24'hAB0000};
      vecs[11] = '{1'b1, 12'd0,    24'h000002, 3'b001, 1'b0, 12'd0,    1'b0, 1'b0, 24'hAB0000, 1'b0, 1'b1, 24'hAB0000};
      vecs[12] = '{1'b1, 12'd0,    24'h000002, 3'b110, 1'b0, 12'd0,    1'b0, 1'b0, 24'hAB0000, 1'b0, 1'b0, 24'h000000};
      vecs[13] = '{1'b1, 12'd5,    24'hFFFFFF, 3'b000, 1'b1, 12'd5,    1'b1, 1'b0, 24'hAA22CC, 1'b0, 1'b0, 24'h000000};
      vecs[14] = '{1'b0, 12'd0,    24'h000000, 3'b000, 1'b1, 12'd7,    1'b1, 1'b0, 24'h0000FF, 1'b0, 1'b0, 24'h000000};
      vecs[15] = '{1'b0, 12'd0,    24'h000000, 3'b000, 1'b1, 12'd5,    1'b1, 1'b0, 24'hAA22CC, 1'b0, 1'b0, 24'h000000};

      // Reset state
      reset_n = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, '0);
      #22;
      chk("rst_ctrl", ctrl_reg, 24'h000F01);
      chk("rst_rd_valid", DW'(rd_valid), '0);
      chk("rst_rd_err", DW'(rd_err), '0);
      chk("rst_wr_err", DW'(wr_err), '0);
      chk("rst_start", DW'(start_pulse), '0);
      chk("rst_rd_data", rd_data, '0);
      reset_n = 1'b1;
      step();

      // Directed vectors
      for (int v = 0; v < 16; v++) begin
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].be, vecs[v].re, vecs[v].ra);
         step();
         chk($sformatf("vec%0d_rd_valid", v), DW'(rd_valid), DW'(vecs[v].e_valid));
         chk($sformatf("vec%0d_rd_err", v), DW'(rd_err), DW'(vecs[v].e_err));
         chk($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].e_data);
         chk($sformatf("vec%0d_wr_err", v), DW'(wr_err), DW'(vecs[v].e_werr));
         chk($sformatf("vec%0d_start", v), DW'(start_pulse), DW'(vecs[v].e_start));
         chk($sformatf("vec%0d_ctrl", v), ctrl_reg, vecs[v].e_ctrl);
      end
      drive(1'b0, '0, '0, '0, 1'b0, '0);
      step();
      chk("idle_rd_valid", DW'(rd_valid), '0);

      // Reset asserted while a read request is pending
      drive(1'b0, '0, '0, '0, 1'b1, 12'd5);
      #3 reset_n = 1'b0;
      step();
      chk("rstrd_rd_valid", DW'(rd_valid), '0);
      chk("rstrd_rd_err", DW'(rd_err), '0);
      chk("rstrd_rd_data", rd_data, '0);
      chk("rstrd_ctrl", ctrl_reg, 24'h000F01);
      drive(1'b0, '0, '0, '0, 1'b0, '0);
      reset_n = 1'b1;
      step();
      chk("rstrd_after_valid", DW'(rd_valid), '0);
      drive(1'b0, '0, '0, '0, 1'b1, 12'd5);
      step();
      chk("rstrd_keep5", rd_data, 24'hAA22CC);
      chk("rstrd_keep5_valid", DW'(rd_valid), 24'd1);
      drive(1'b0, '0, '0, '0, 1'b1, 12'd7);
      step();
      chk("rstrd_keep7", rd_data, 24'h0000FF);

      // Randomized traffic against the model
      exp_rd   = 24'h0000FF;
      model[0] = 24'h000F01;
      for (int a = 1; a < int'(NMOD); a++) begin
         model_cycle(1'b1, AW'(a), DW'($urandom), 3'b111, 1'b0, '0);
      end
      for (int n = 0; n < 400; n++) begin
         model_cycle(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom), NB'($urandom),
                     1'($urandom_range(0, 1)), rand_addr());
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
